// File: rtl/dsss_spreader.sv
// DSSS spreader: one data bit per 31-chip PN period (x^5+x^2+1), 8 samples per chip.
// Define DSSS_DIFF_EN to differentially encode accepted bits before spreading.
`timescale 1ns/1ps
module dsss_spreader #(
  parameter int unsigned SPS     = 8,
  parameter logic [4:0]  PN_SEED = 5'b11111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       chip_out,
  output logic       pn_out,
  output logic [7:0] addr_out,
  output logic       epoch,
  output logic       sym_active,
  output logic       underflow
);

  localparam int unsigned CHIPS    = 31;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned LFSR_W   = 5;
  localparam int unsigned IDX_LAST = CHIPS * SPS - 1;

  typedef enum logic {
    PER_IDLE,
    PER_ACTIVE
  } per_state_e;

  per_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic              tx_q;
  logic              last_sample;
  logic              chip_step;
  logic              accept;
  logic              tx_bit_new;
  logic              active;

`ifdef DSSS_DIFF_EN
  logic prev_q;

  // Differential reference only moves on accepted bits; idle periods leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else if (accept) begin
      prev_q <= tx_bit_new;
    end
  end

  assign tx_bit_new = din ^ prev_q;
`else
  assign tx_bit_new = din;
`endif

  // Period handshake and next-period state decision.
  always_comb begin
    state_d     = state_q;
    last_sample = (idx_q == IDX_W'(IDX_LAST));
    chip_step   = (idx_q[2:0] == 3'(SPS - 1));
    din_ready   = rst & en & last_sample;
    accept      = din_ready & din_valid;
    active      = (state_q == PER_ACTIVE);
    if (en && last_sample) begin
      state_d = accept ? PER_ACTIVE : PER_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PER_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample index, PN generator and held data bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      lfsr_q <= PN_SEED;
      tx_q   <= 1'b0;
    end else if (en) begin
      idx_q <= last_sample ? '0 : idx_q + IDX_W'(1);
      if (last_sample) begin
        lfsr_q <= PN_SEED;
      end else if (chip_step) begin
        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2], lfsr_q[4:1]};
      end
      if (accept) begin
        tx_q <= tx_bit_new;
      end
    end
  end

  // Output stage: one sample of latency, frozen while en is low except the pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chip_out   <= 1'b0;
      pn_out     <= 1'b0;
      addr_out   <= '0;
      epoch      <= 1'b0;
      sym_active <= 1'b0;
      underflow  <= 1'b0;
    end else if (en) begin
      chip_out   <= active & (lfsr_q[0] ^ tx_q);
      pn_out     <= lfsr_q[0];
      addr_out   <= idx_q;
      epoch      <= (idx_q == '0);
      sym_active <= active;
      underflow  <= (idx_q == '0) & ~active;
    end else begin
      epoch     <= 1'b0;
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsss_spreader.sv
// Directed bench for dsss_spreader with a behavioural model feeding a scoreboard queue.
`timescale 1ns/1ps
module tb_dsss_spreader;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       chip_out;
  logic       pn_out;
  logic [7:0] addr_out;
  logic       epoch;
  logic       sym_active;
  logic       underflow;

  dsss_spreader #(.SPS(8), .PN_SEED(5'b11111)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .chip_out   (chip_out),
    .pn_out     (pn_out),
    .addr_out   (addr_out),
    .epoch      (epoch),
    .sym_active (sym_active),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       chip;
    logic       pn;
    logic [7:0] addr;
    logic       epoch;
    logic       sym;
    logic       under;
  } exp_t;

  exp_t sb[$];
  logic tx_obs[$];
  logic pn_tab[31];
  logic head[6];
  logic tx_ref[3];

  int   n_total;
  int   n_pass;
  int   m_idx;
  logic m_active;
  logic m_tx;
  logic m_prev;
  exp_t m_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_idx        = 0;
    m_active     = 1'b0;
    m_tx         = 1'b0;
    m_prev       = 1'b0;
    m_last.chip  = 1'b0;
    m_last.pn    = 1'b0;
    m_last.addr  = 8'd0;
    m_last.epoch = 1'b0;
    m_last.sym   = 1'b0;
    m_last.under = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_chip"}, 32'(chip_out), 32'd0);
    check({tag, "_pn"}, 32'(pn_out), 32'd0);
    check({tag, "_addr"}, 32'(addr_out), 32'd0);
    check({tag, "_epoch"}, 32'(epoch), 32'd0);
    check({tag, "_sym"}, 32'(sym_active), 32'd0);
    check({tag, "_under"}, 32'(underflow), 32'd0);
  endtask

  // One sample: drive, predict, push; then after the edge pop and compare.
  task automatic step(input logic e, input logic dv, input logic d);
    exp_t x;
    logic bitv;
    @(negedge clk);
    en        = e;
    din_valid = dv;
    din       = d;
    #1;
    check("din_ready", 32'(din_ready), 32'(e && (m_idx == 247)));
    x = m_last;
    x.epoch = 1'b0;
    x.under = 1'b0;
    if (e) begin
      x.addr  = 8'(m_idx);
      x.pn    = pn_tab[m_idx / 8];
      x.sym   = m_active;
      x.chip  = m_active ? (pn_tab[m_idx / 8] ^ m_tx) : 1'b0;
      x.epoch = (m_idx == 0);
      x.under = (m_idx == 0) && !m_active;
      if (m_idx == 247) begin
        if (dv) begin
`ifdef DSSS_DIFF_EN
          bitv = d ^ m_prev;
`else
          bitv = d;
`endif
          m_tx     = bitv;
          m_prev   = bitv;
          m_active = 1'b1;
        end else begin
          m_active = 1'b0;
        end
        m_idx = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
    m_last = x;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("chip_out", 32'(chip_out), 32'(x.chip));
    check("pn_out", 32'(pn_out), 32'(x.pn));
    check("addr_out", 32'(addr_out), 32'(x.addr));
    check("epoch", 32'(epoch), 32'(x.epoch));
    check("sym_active", 32'(sym_active), 32'(x.sym));
    check("underflow", 32'(underflow), 32'(x.under));
    if (epoch === 1'b1 && sym_active === 1'b1) begin
      tx_obs.push_back(chip_out ^ pn_out);
    end
  endtask

  initial begin
    logic [4:0] s;
    int acc;
    n_total = 0;
    n_pass  = 0;
    s = 5'b11111;
    for (int i = 0; i < 31; i++) begin
      pn_tab[i] = s[0];
      s = {s[0] ^ s[2], s[4:1]};
    end
    head = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef DSSS_DIFF_EN
    tx_ref = '{1'b1, 1'b0, 1'b0};
`else
    tx_ref = '{1'b1, 1'b1, 1'b0};
`endif
    model_reset();
    rst       = 1'b0;
    en        = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;

    // Held in reset with en high: everything stays at zero.
    repeat (3) begin
      @(negedge clk);
      en = 1'b1;
      din_valid = 1'b1;
      #1;
      check("rst_din_ready", 32'(din_ready), 32'd0);
      @(posedge clk);
      #1;
      check_zero("rst");
    end
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    din_valid = 1'b0;

    // First period is idle; PN head checked against the known chip pattern.
    for (int i = 0; i < 247; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if ((i % 8) == 0 && i < 48) check("pn_head", 32'(pn_out), 32'(head[i / 8]));
    end
    // din=1 held valid: accepted at the end of periods 1 and 2.
    for (int i = 0; i < 496; i++) step(1'b1, 1'b1, 1'b1);
    // No offer at the end of period 3, so period 4 idles.
    for (int i = 0; i < 248; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    // Gapped enable inside period 5; din_valid during en=0 must be ignored.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
    end
    while (m_idx != 247) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    while (m_idx != 100) step(1'b1, 1'b0, 1'b0);

    // Async reset in the middle of an active period.
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    #1;
    check("midrst_din_ready", 32'(din_ready), 32'd0);
    check_zero("midrst_async");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("midrst");
    end
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;

    // Ten periods: PN balance of 16 ones per 31 chips (8 samples each -> 128).
    for (int p = 0; p < 10; p++) begin
      acc = 0;
      for (int i = 0; i < 248; i++) begin
        step(1'b1, 1'b0, 1'b0);
        acc += int'(pn_out);
      end
      check("pn_balance", 32'(acc), 32'd128);
    end

    check("tx_count", 32'(tx_obs.size() >= 3), 32'd1);
    if (tx_obs.size() >= 3) begin
      for (int k = 0; k < 3; k++) check("tx_bit", 32'(tx_obs[k]), 32'(tx_ref[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsss_spreader.md
DSSS_SPREADER -- requirements
Module: dsss_spreader

Interface
REQ-001 Parameter SPS, default 8, samples per chip (fixed at 8; any other value is out of scope).
REQ-002 Parameter PN_SEED, default 5'b11111, LFSR load value at reset and at each period wrap.
REQ-003 clk  in  1  system clock, 49.6 MHz.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 en  in  1  sample-rate enable; all state advances only when en=1.
REQ-006 din  in  1  data bit to spread.
REQ-007 din_valid  in  1  din is valid.
REQ-008 din_ready  out  1  block accepts din this cycle.
REQ-009 chip_out  out  1  spread output, data XOR PN, 8 samples per chip.
REQ-010 pn_out  out  1  unmodulated PN chip at the same sample as chip_out.
REQ-011 addr_out  out  8  sample index 0..247 of chip_out within the PN period.
REQ-012 epoch  out  1  one-cycle pulse when addr_out=0.
REQ-013 sym_active  out  1  current period carries an accepted data bit.
REQ-014 underflow  out  1  one-cycle pulse with epoch when the period is idle.

Function
REQ-015 The internal sample index idx counts 0..247 (31 chips x 8) on each en cycle and wraps 247->0.
REQ-016 The PN generator is a 5-bit Fibonacci LFSR s[4:0] for x^5+x^2+1: chip = s[0]; on a chip step, shift right with s[4] <= s[0]^s[2].
REQ-017 The LFSR steps when idx[2:0]=7 and en=1; at idx=247 it reloads PN_SEED instead, giving exactly 31 chips per period.
REQ-018 With PN_SEED=11111 the first six chips of every period are 1,1,1,1,1,0.
REQ-019 din_ready = en AND (idx=247), combinational, and 0 while rst is asserted.
REQ-020 A bit is accepted when din_valid AND din_ready; it modulates the whole next period (idx 0..247).
REQ-021 Without acceptance at idx=247, the next period is idle: chip_out=0, sym_active=0, underflow pulses with epoch.
REQ-022 The first period after reset is always idle.
REQ-023 All outputs except din_ready are registered: the values for idx=k appear one clk after the en cycle in which idx=k; latency is 1.
REQ-024 In an active period, chip_out = pn_out XOR tx_bit, where tx_bit is the accepted bit or its encoded form (REQ-030).
REQ-025 en=0 freezes idx, LFSR, tx_bit and all registered outputs; epoch and underflow are 0 on the cycle after an en=0 cycle.
REQ-026 din_valid without din_ready is ignored, and din is not sampled.

Reset
REQ-027 While rst=0: idx=0, LFSR=PN_SEED, tx_bit=0, and chip_out, pn_out, addr_out, epoch, sym_active, underflow are all 0.
REQ-028 Reset asserted mid-period aborts the current symbol immediately; any bit accepted for the next period is discarded.
REQ-029 The first en cycle after reset release emits idx=0, with epoch=1 and underflow=1 one clk later.

Configuration
REQ-030 With DSSS_DIFF_EN defined, tx_bit = din XOR prev; prev resets to 0 and updates only on accepted bits, not on idle periods.
REQ-031 Without DSSS_DIFF_EN, tx_bit = din, and no prev register exists.

Verification
REQ-032 Reset release, en=1 constant, no din_valid -> epoch every 248 clks, underflow with each epoch, chip_out=0, pn_out chips 1,1,1,1,1,0 each held 8 samples.
REQ-033 din_valid=1, din=1 held -> accepted at idx=247; the next period has sym_active=1 and chip_out = NOT pn_out for all 248 samples.
REQ-034 en toggled 1,0,1,0 with active data -> addr_out advances exactly once per en cycle; the pn_out sequence matches the en=1 reference.
REQ-035 rst pulsed at idx=100 of an active period -> all outputs 0 during reset; the period after release is idle with underflow=1.
REQ-036 DSSS_DIFF_EN defined, bits 1,1,0 accepted with an idle period between the 2nd and 3rd -> tx_bit 1,0,0; without the macro -> 1,1,0.
REQ-037 Over 10 periods, pn_out sums to 16 ones per period (m-sequence balance), and the LFSR never reaches 00000.
